// File: rtl/gray_to_bin_sync.sv
// rtl/gray_to_bin_sync.sv - synchronizes a Gray-coded bus and decodes it to binary with step/error reporting
//
// Ports:
//   CLK   : single clock, all flops rising-edge
//   RSTN  : asynchronous active-low reset
//   G     : Gray-coded bus, asynchronous to CLK
//   CLR   : synchronous clear of the sticky error flag
//   B     : registered binary value of the last accepted Gray sample
//   VALID : one-cycle pulse when B changes
//   DIR   : 1 = last legal step was +1, 0 = -1 (mod 2^W)
//   ERR   : one-cycle pulse when the accepted sample differed in 2+ bits
//   ERRS  : sticky error flag
module gray_to_bin_sync #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [W-1:0] G,
    input  logic         CLR,
    output logic [W-1:0] B,
    output logic         VALID,
    output logic         DIR,
    output logic         ERR,
    output logic         ERRS
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [W-1:0]  ONE        = W'(1);
    localparam logic [CW-1:0] PRIME_LAST = CW'(SYNC_STAGES);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  s;
    logic [W-1:0]  bn;
    logic [W-1:0]  p_q;
    logic [W-1:0]  diff;
    logic          changed;
    logic          multi;
    logic [CW-1:0] prime_cnt;
    logic          primed;

    // Plain flop chain: no logic between stages so each stage can resolve metastability.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= G;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar gi = 0; gi < W; gi++) begin : g_decode
        assign bn[gi] = ^s[W-1:gi];
    end

    // Two or more differing bits: nonzero and not a power of two.
    assign diff    = s ^ p_q;
    assign changed = |diff;
    assign multi   = changed && (|(diff & (diff - ONE)));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            p_q       <= '0;
            B         <= '0;
            VALID     <= 1'b0;
            DIR       <= 1'b0;
            ERR       <= 1'b0;
            ERRS      <= 1'b0;
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            if (!primed) begin
                // Wait for the synchronizer to fill, then load the first sample silently.
                if (prime_cnt != PRIME_LAST) begin
                    prime_cnt <= prime_cnt + 1'b1;
                end else begin
                    p_q    <= s;
                    B      <= bn;
                    primed <= 1'b1;
                end
                if (CLR) begin
                    ERRS <= 1'b0;
                end
            end else begin
                if (changed) begin
                    B     <= bn;
                    p_q   <= s;
                    VALID <= 1'b1;
                    if (multi) begin
                        // Resynchronise to the new value; direction is meaningless here.
                        ERR <= 1'b1;
                    end else begin
                        DIR <= (bn == (B + ONE));
                    end
                end
                // A fresh error wins over a simultaneous clear.
                if (changed && multi) begin
                    ERRS <= 1'b1;
                end else if (CLR) begin
                    ERRS <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_to_bin_sync.sv
// tb/tb_gray_to_bin_sync.sv - directed self-checking bench for gray_to_bin_sync
module tb_gray_to_bin_sync;

    localparam int W = 4;

    logic         CLK;
    logic         RSTN;
    logic [W-1:0] G;
    logic         CLR;
    logic [W-1:0] B;
    logic         VALID;
    logic         DIR;
    logic         ERR;
    logic         ERRS;

    int checks = 0;
    int errors = 0;

    gray_to_bin_sync #(.W(W), .SYNC_STAGES(2)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .G     (G),
        .CLR   (CLR),
        .B     (B),
        .VALID (VALID),
        .DIR   (DIR),
        .ERR   (ERR),
        .ERRS  (ERRS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reset, present g, release, and let the block prime (3 edges).
    task automatic prime(input logic [W-1:0] g, input logic [W-1:0] exp_b);
        RSTN = 1'b0;
        #1;
        G    = g;
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prime_valid", {3'b0, VALID}, 4'b0);
            chk("prime_err", {3'b0, ERR}, 4'b0);
        end
        chk("prime_b", B, exp_b);
    endtask

    // Present g and check the response 3 edges later plus pulse width.
    task automatic step(input string tag, input logic [W-1:0] g, input logic [W-1:0] exp_b,
                        input logic exp_dir, input logic exp_err, input logic exp_errs);
        G = g;
        tick();
        tick();
        chk({tag, "_early_valid"}, {3'b0, VALID}, 4'b0);
        tick();
        chk({tag, "_b"}, B, exp_b);
        chk({tag, "_valid"}, {3'b0, VALID}, 4'b1);
        chk({tag, "_dir"}, {3'b0, DIR}, {3'b0, exp_dir});
        chk({tag, "_err"}, {3'b0, ERR}, {3'b0, exp_err});
        chk({tag, "_errs"}, {3'b0, ERRS}, {3'b0, exp_errs});
        tick();
        chk({tag, "_valid_drop"}, {3'b0, VALID}, 4'b0);
        chk({tag, "_err_drop"}, {3'b0, ERR}, 4'b0);
    endtask

    initial begin
        // 1. Reset without a clock edge
        RSTN = 1'b0;
        G    = 4'b1010;
        CLR  = 1'b0;
        #1;
        chk("rst_b", B, 4'b0000);
        chk("rst_valid", {3'b0, VALID}, 4'b0);
        chk("rst_dir", {3'b0, DIR}, 4'b0);
        chk("rst_err", {3'b0, ERR}, 4'b0);
        chk("rst_errs", {3'b0, ERRS}, 4'b0);

        // 2. Priming with G=0110 -> B=0100
        prime(4'b0110, 4'b0100);

        // 3. Legal steps
        prime(4'b0000, 4'b0000);
        step("up1", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        step("dn1", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hold_b", B, 4'b0000);
        chk("hold_valid", {3'b0, VALID}, 4'b0);

        // 4. Wrap-around
        prime(4'b1000, 4'b1111);
        step("wrap_up", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("wrap_dn", 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);

        // 5. Multi-bit error, DIR held at 1 from the preceding up step
        prime(4'b0000, 4'b0000);
        step("pre_err_up", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        step("multi", 4'b0010, 4'b0011, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("errs_sticky", {3'b0, ERRS}, 4'b1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("errs_cleared", {3'b0, ERRS}, 4'b0);

        // CLR coinciding with a new error: set wins
        G = 4'b0111;
        tick();
        tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("set_wins_b", B, 4'b0101);
        chk("set_wins_err", {3'b0, ERR}, 4'b1);
        chk("set_wins_errs", {3'b0, ERRS}, 4'b1);
        tick();
        chk("set_wins_errs_hold", {3'b0, ERRS}, 4'b1);

        // 6. Async reset mid-run at B=0101
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_b", B, 4'b0000);
        chk("mid_rst_dir", {3'b0, DIR}, 4'b0);
        chk("mid_rst_errs", {3'b0, ERRS}, 4'b0);
        chk("mid_rst_valid", {3'b0, VALID}, 4'b0);
        chk("mid_rst_err", {3'b0, ERR}, 4'b0);
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reprime_valid", {3'b0, VALID}, 4'b0);
        end
        chk("reprime_b", B, 4'b0101);
        chk("reprime_errs", {3'b0, ERRS}, 4'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
